// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer control. It is a circular buffer of ROB_SIZE entries
// that is allocated in program order, completed out of order by writeback, and
// committed in order from the head. When a taken branch commits, the whole
// buffer is flushed.
// Optional feature: define TARTARUGA_ROB_COMMIT_BYPASS_EN so that a full
// buffer can accept an allocation in the same cycle that its head commits.
module rob_ctrl #(
  parameter  int unsigned ROB_SIZE = 16,
  localparam int unsigned IDX_BITS = $clog2(ROB_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_valid_i,
  input  logic [31:0]         alloc_pc_i,
  input  logic [31:0]         alloc_instr_i,
  input  logic [4:0]          alloc_rd_i,
  input  logic                alloc_we_i,
  input  logic                alloc_store_i,
  output logic                alloc_ready_o,
  output logic [IDX_BITS-1:0] alloc_idx_o,
  input  logic                wb_valid_i,
  input  logic [IDX_BITS-1:0] wb_idx_i,
  input  logic [31:0]         wb_result_i,
  input  logic                wb_branch_taken_i,
  input  logic [31:0]         wb_new_pc_i,
  output logic                commit_valid_o,
  input  logic                commit_ready_i,
  output logic [31:0]         commit_pc_o,
  output logic [4:0]          commit_rd_o,
  output logic                commit_we_o,
  output logic                commit_store_o,
  output logic [31:0]         commit_result_o,
  output logic                flush_o,
  output logic [31:0]         flush_pc_o,
  output logic [IDX_BITS:0]   count_o
);

  localparam logic [IDX_BITS:0]   FULL_CNT = (IDX_BITS+1)'(ROB_SIZE);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

  // Control state
  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] completed_q, completed_d;
  logic [IDX_BITS-1:0] head_q, head_d;
  logic [IDX_BITS-1:0] tail_q, tail_d;
  logic [IDX_BITS:0]   count_q, count_d;

  // Entry payload. It needs no reset because valid/completed gate every use.
  logic [31:0] pc_q     [ROB_SIZE];
  logic [4:0]  rd_q     [ROB_SIZE];
  logic        we_q     [ROB_SIZE];
  logic        store_q  [ROB_SIZE];
  logic [31:0] result_q [ROB_SIZE];
  logic        taken_q  [ROB_SIZE];
  logic [31:0] new_pc_q [ROB_SIZE];

  logic alloc_fire, commit_fire, flush_fire, wb_hit;

  // The commit path never uses the instruction word.
  logic unused_instr;
  assign unused_instr = ^alloc_instr_i;

  assign commit_valid_o = valid_q[head_q] && completed_q[head_q];
  assign flush_o        = commit_valid_o && taken_q[head_q];
  assign commit_fire    = commit_valid_o && commit_ready_i;
  assign flush_fire     = commit_fire && flush_o;
  assign wb_hit         = wb_valid_i && valid_q[wb_idx_i];

`ifdef TARTARUGA_ROB_COMMIT_BYPASS_EN
  assign alloc_ready_o = ((count_q < FULL_CNT) || commit_fire) && !flush_o;
`else
  assign alloc_ready_o = (count_q < FULL_CNT) && !flush_o;
`endif

  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign alloc_idx_o = tail_q;
  assign count_o     = count_q;

  // Head fields are driven as zero while no commit is presented.
  assign commit_pc_o     = commit_valid_o ? pc_q[head_q]     : '0;
  assign commit_rd_o     = commit_valid_o ? rd_q[head_q]     : '0;
  assign commit_we_o     = commit_valid_o ? we_q[head_q]     : 1'b0;
  assign commit_store_o  = commit_valid_o ? store_q[head_q]  : 1'b0;
  assign commit_result_o = commit_valid_o ? result_q[head_q] : '0;
  assign flush_pc_o      = flush_o        ? new_pc_q[head_q] : '0;

  // Next-state logic. The order wb -> commit -> alloc matters: with the bypass,
  // tail equals the committing head, so the allocation must be the last write.
  always_comb begin
    valid_d     = valid_q;
    completed_d = completed_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (flush_fire) begin
      valid_d     = '0;
      completed_d = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
    end else begin
      if (wb_hit) completed_d[wb_idx_i] = 1'b1;
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + IDX_ONE;
      end
      if (alloc_fire) begin
        valid_d[tail_q]     = 1'b1;
        completed_d[tail_q] = 1'b0;
        tail_d              = tail_q + IDX_ONE;
      end
      count_d = count_q + {{IDX_BITS{1'b0}}, alloc_fire}
                        - {{IDX_BITS{1'b0}}, commit_fire};
    end
  end

  // Control registers. Reset takes precedence over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      completed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      completed_q <= completed_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Payload capture on allocation and on writeback to a live entry.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]    <= alloc_pc_i;
      rd_q[tail_q]    <= alloc_rd_i;
      we_q[tail_q]    <= alloc_we_i;
      store_q[tail_q] <= alloc_store_i;
    end
    if (wb_hit) begin
      result_q[wb_idx_i] <= wb_result_i;
      taken_q[wb_idx_i]  <= wb_branch_taken_i;
      new_pc_q[wb_idx_i] <= wb_new_pc_i;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: checks rob_ctrl (ROB_SIZE=16) with a table of vectors and a few
// hand-written multi-cycle sequences. Honors TARTARUGA_ROB_COMMIT_BYPASS_EN.
module tb_rob_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid_i;
  logic [31:0] alloc_pc_i, alloc_instr_i;
  logic [4:0]  alloc_rd_i;
  logic        alloc_we_i, alloc_store_i;
  logic        alloc_ready_o;
  logic [3:0]  alloc_idx_o;
  logic        wb_valid_i;
  logic [3:0]  wb_idx_i;
  logic [31:0] wb_result_i, wb_new_pc_i;
  logic        wb_branch_taken_i;
  logic        commit_valid_o, commit_ready_i;
  logic [31:0] commit_pc_o, commit_result_o;
  logic [4:0]  commit_rd_o;
  logic        commit_we_o, commit_store_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic [4:0]  count_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  rob_ctrl #(.ROB_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i),
    .alloc_instr_i(alloc_instr_i), .alloc_rd_i(alloc_rd_i),
    .alloc_we_i(alloc_we_i), .alloc_store_i(alloc_store_i),
    .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .wb_branch_taken_i(wb_branch_taken_i), .wb_new_pc_i(wb_new_pc_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_pc_o(commit_pc_o), .commit_rd_o(commit_rd_o),
    .commit_we_o(commit_we_o), .commit_store_o(commit_store_o),
    .commit_result_o(commit_result_o), .flush_o(flush_o),
    .flush_pc_o(flush_pc_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        wv;
    logic [3:0]  wi;
    logic [31:0] wres;
    logic        wtk;
    logic [31:0] wnpc;
    logic        cr;
    logic        e_ready;
    logic [3:0]  e_idx;
    logic        e_cv;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
    logic        e_fl;
    logic [31:0] e_fpc;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    alloc_valid_i = 0; alloc_pc_i = '0; alloc_instr_i = '0; alloc_rd_i = '0;
    alloc_we_i = 0; alloc_store_i = 0;
    wb_valid_i = 0; wb_idx_i = '0; wb_result_i = '0; wb_branch_taken_i = 0;
    wb_new_pc_i = '0; commit_ready_i = 0;
  endtask

  // Advance one clock; return just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, ".ready"},  32'(alloc_ready_o),   32'd1);
    chk({tag, ".idx"},    32'(alloc_idx_o),     32'd0);
    chk({tag, ".cv"},     32'(commit_valid_o),  32'd0);
    chk({tag, ".flush"},  32'(flush_o),         32'd0);
    chk({tag, ".count"},  32'(count_o),         32'd0);
    chk({tag, ".pc"},     commit_pc_o,          32'd0);
    chk({tag, ".rd"},     32'(commit_rd_o),     32'd0);
    chk({tag, ".we"},     32'(commit_we_o),     32'd0);
    chk({tag, ".store"},  32'(commit_store_o),  32'd0);
    chk({tag, ".result"}, commit_result_o,      32'd0);
  endtask

  task automatic alloc_op(input logic [4:0] rd, input logic [31:0] pc);
    alloc_valid_i = 1; alloc_rd_i = rd; alloc_pc_i = pc; alloc_we_i = 1;
    alloc_instr_i = pc ^ 32'h1357_9bdf;
  endtask

  initial begin
    // rst av rd pc | wv wi wres wtk wnpc | cr || ready idx cv rd res fl fpc cnt
    // In-order commit of out-of-order writebacks.
    vt.push_back('{0,1,1,'h10, 0,0,0,0,0, 0, 1,0,0,0,0,0,0,0});
    vt.push_back('{0,1,2,'h14, 0,0,0,0,0, 0, 1,1,0,0,0,0,0,1});
    vt.push_back('{0,1,3,'h18, 0,0,0,0,0, 0, 1,2,0,0,0,0,0,2});
    vt.push_back('{0,0,0,0, 1,2,'h300,0,0, 1, 1,3,0,0,0,0,0,3});
    vt.push_back('{0,0,0,0, 1,0,'h100,0,0, 1, 1,3,0,0,0,0,0,3});
    vt.push_back('{0,0,0,0, 1,1,'h200,0,0, 1, 1,3,1,1,'h100,0,0,3});
    vt.push_back('{0,0,0,0, 0,0,0,0,0, 1, 1,3,1,2,'h200,0,0,2});
    vt.push_back('{0,0,0,0, 0,0,0,0,0, 1, 1,3,1,3,'h300,0,0,1});
    vt.push_back('{0,0,0,0, 0,0,0,0,0, 1, 1,3,0,0,0,0,0,0});
    // Taken branch flush; same-cycle alloc and wb are ignored.
    vt.push_back('{1,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,0,0,0});
    vt.push_back('{0,1,4,'h20, 0,0,0,0,0, 0, 1,0,0,0,0,0,0,0});
    vt.push_back('{0,1,5,'h24, 0,0,0,0,0, 0, 1,1,0,0,0,0,0,1});
    vt.push_back('{0,1,6,'h28, 0,0,0,0,0, 0, 1,2,0,0,0,0,0,2});
    vt.push_back('{0,1,7,'h2c, 0,0,0,0,0, 0, 1,3,0,0,0,0,0,3});
    vt.push_back('{0,0,0,0, 1,1,'h55,1,'h100, 0, 1,4,0,0,0,0,0,4});
    vt.push_back('{0,0,0,0, 1,0,'h44,0,0, 0, 1,4,0,0,0,0,0,4});
    vt.push_back('{0,0,0,0, 0,0,0,0,0, 1, 1,4,1,4,'h44,0,0,4});
    vt.push_back('{0,1,9,'h30, 1,2,'h66,0,0, 1, 0,4,1,5,'h55,1,'h100,3});
    vt.push_back('{0,0,0,0, 1,2,'h77,0,0, 1, 1,0,0,0,0,0,0,0});
    vt.push_back('{0,0,0,0, 0,0,0,0,0, 1, 1,0,0,0,0,0,0,0});

    // Outputs after reset
    do_reset();
    check_reset_outputs("rst0");

    // Vector table
    for (int i = 0; i < vt.size(); i++) begin
      clr_inputs();
      reset = vt[i].rst;
      alloc_valid_i = vt[i].av; alloc_rd_i = vt[i].rd; alloc_pc_i = vt[i].pc;
      alloc_we_i = vt[i].av;
      wb_valid_i = vt[i].wv; wb_idx_i = vt[i].wi; wb_result_i = vt[i].wres;
      wb_branch_taken_i = vt[i].wtk; wb_new_pc_i = vt[i].wnpc;
      commit_ready_i = vt[i].cr;
      #1;
      if (!vt[i].rst) begin
        chk($sformatf("v%0d.ready", i), 32'(alloc_ready_o),  32'(vt[i].e_ready));
        chk($sformatf("v%0d.idx", i),   32'(alloc_idx_o),    32'(vt[i].e_idx));
        chk($sformatf("v%0d.cv", i),    32'(commit_valid_o), 32'(vt[i].e_cv));
        chk($sformatf("v%0d.flush", i), 32'(flush_o),        32'(vt[i].e_fl));
        chk($sformatf("v%0d.count", i), 32'(count_o),        32'(vt[i].e_cnt));
        if (vt[i].e_cv) begin
          chk($sformatf("v%0d.rd", i),  32'(commit_rd_o),    32'(vt[i].e_rd));
          chk($sformatf("v%0d.res", i), commit_result_o,     vt[i].e_res);
        end
        if (vt[i].e_fl)
          chk($sformatf("v%0d.fpc", i), flush_pc_o,          vt[i].e_fpc);
      end
      tick();
    end
    reset = 0;

    // Fill to capacity, then free one slot by committing the head
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_op(5'(i + 1), 32'h200 + 32'(i) * 4);
      #1;
      chk($sformatf("fill%0d.idx", i), 32'(alloc_idx_o), 32'(i));
      chk($sformatf("fill%0d.ready", i), 32'(alloc_ready_o), 32'd1);
      tick();
    end
    clr_inputs();
    #1;
    chk("full.ready", 32'(alloc_ready_o), 32'd0);
    chk("full.count", 32'(count_o), 32'd16);
    wb_valid_i = 1; wb_idx_i = 0; wb_result_i = 32'hcafe;
    tick();
    clr_inputs();
    commit_ready_i = 1;
    alloc_op(5'd20, 32'h900);
    #1;
    chk("fullc.cv", 32'(commit_valid_o), 32'd1);
`ifdef TARTARUGA_ROB_COMMIT_BYPASS_EN
    chk("fullc.ready", 32'(alloc_ready_o), 32'd1);
`else
    chk("fullc.ready", 32'(alloc_ready_o), 32'd0);
`endif
    tick();
    clr_inputs();
    #1;
`ifdef TARTARUGA_ROB_COMMIT_BYPASS_EN
    chk("after.count", 32'(count_o), 32'd16);
    chk("after.ready", 32'(alloc_ready_o), 32'd0);
    chk("after.idx", 32'(alloc_idx_o), 32'd1);
`else
    chk("after.count", 32'(count_o), 32'd15);
    chk("after.ready", 32'(alloc_ready_o), 32'd1);
    chk("after.idx", 32'(alloc_idx_o), 32'd0);
`endif

    // 20 alloc/wb/commit rounds so the tail wraps 15 -> 0
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alloc_op(5'(i % 32), 32'h1000 + 32'(i));
      #1;
      chk($sformatf("wrap%0d.idx", i), 32'(alloc_idx_o), 32'(i % 16));
      tick();
      clr_inputs();
      wb_valid_i = 1; wb_idx_i = 4'(i % 16); wb_result_i = 32'(i) * 3 + 7;
      tick();
      clr_inputs();
      commit_ready_i = 1;
      #1;
      chk($sformatf("wrap%0d.cv", i), 32'(commit_valid_o), 32'd1);
      chk($sformatf("wrap%0d.res", i), commit_result_o, 32'(i) * 3 + 7);
      tick();
      clr_inputs();
    end
    #1;
    chk("wrap.count", 32'(count_o), 32'd0);

    // Commit back-pressure, then reset with pending entries
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc_op(5'(i + 10), 32'h400 + 32'(i) * 4);
      tick();
    end
    clr_inputs();
    wb_valid_i = 1; wb_idx_i = 0; wb_result_i = 32'habc;
    tick();
    clr_inputs();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold%0d.cv", i), 32'(commit_valid_o), 32'd1);
      chk($sformatf("hold%0d.rd", i), 32'(commit_rd_o), 32'd10);
      chk($sformatf("hold%0d.pc", i), commit_pc_o, 32'h400);
      chk($sformatf("hold%0d.res", i), commit_result_o, 32'habc);
      chk($sformatf("hold%0d.count", i), 32'(count_o), 32'd6);
      tick();
    end
    reset = 1;
    commit_ready_i = 1;
    alloc_op(5'd30, 32'h777);
    tick();
    reset = 0;
    clr_inputs();
    check_reset_outputs("rst1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
